// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file geometry and decoded-instruction bundle
package rf_pkg;
  localparam int DATA_W   = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic [AW-1:0] rd;
    logic          rd_we;
  } instr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - in-flight destination tracking with set-over-clear priority
module rf_scoreboard #(
  parameter int AW       = rf_pkg::AW,
  parameter int NUM_REGS = 2 ** AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [AW-1:0]       set_idx,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_idx,
  input  logic [AW-1:0]       rs_a,
  input  logic [AW-1:0]       rs_b,
  input  logic [AW-1:0]       rd,
  output logic                busy_a,
  output logic                busy_b,
  output logic                busy_rd,
  output logic [NUM_REGS-1:0] pending
);
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    pending_d = pending_q & ~clr_mask;
    // A new producer for the same register outranks the retiring one.
    if (set_en) pending_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A register being written back this cycle is already readable via bypass.
  assign busy_a  = pending_q[rs_a] & ~clr_mask[rs_a];
  assign busy_b  = pending_q[rs_b] & ~clr_mask[rs_b];
  assign busy_rd = pending_q[rd]   & ~clr_mask[rd];
  assign pending = pending_q;
endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch with writeback bypass, scoreboard stalls and output register
module operand_fetch_stage #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int AW     = rf_pkg::AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs_a,
  input  logic [AW-1:0]     in_rs_b,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_rd_we,
  output logic [AW-1:0]     rf_address_a,
  output logic [AW-1:0]     rf_address_b,
  output logic              rf_enable_a,
  output logic              rf_enable_b,
  input  logic [DATA_W-1:0] rf_OutA,
  input  logic [DATA_W-1:0] rf_OutB,
  output logic [AW-1:0]     rf_address_w,
  output logic              rf_enable_w,
  output logic [DATA_W-1:0] rf_In,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [AW-1:0]     out_rd,
  output logic              out_rd_we,
  output logic [CNT_W-1:0]  stall_cnt
);
  import rf_pkg::instr_t;

  instr_t              in_instr;
  logic                busy_a, busy_b, busy_rd;
  logic                hazard, accept;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [2**AW-1:0]    pending;

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
  logic [AW-1:0]       out_rd_q, out_rd_d;
  logic                out_rd_we_q, out_rd_we_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  assign in_instr = '{rs_a: in_rs_a, rs_b: in_rs_b, rd: in_rd, rd_we: in_rd_we};

  assign rf_address_a = in_instr.rs_a;
  assign rf_address_b = in_instr.rs_b;
  assign rf_enable_a  = in_valid;
  assign rf_enable_b  = in_valid;
  assign rf_address_w = wb_rd;
  assign rf_enable_w  = wb_valid;
  assign rf_In        = wb_data;

  rf_scoreboard #(.AW(AW)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (accept & in_instr.rd_we),
    .set_idx (in_instr.rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .rs_a    (in_instr.rs_a),
    .rs_b    (in_instr.rs_b),
    .rd      (in_instr.rd),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .busy_rd (busy_rd),
    .pending (pending)
  );

  // The register file only commits at the edge, so same-cycle writeback must be muxed in here.
  assign op_a = (wb_valid && wb_rd == in_instr.rs_a) ? wb_data : rf_OutA;
  assign op_b = (wb_valid && wb_rd == in_instr.rs_b) ? wb_data : rf_OutB;

  assign hazard   = in_valid & (busy_a | busy_b | (in_instr.rd_we & busy_rd));
  assign in_ready = ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = op_a;
      out_b_d     = op_b;
      out_rd_d    = in_instr.rd;
      out_rd_we_d = in_instr.rd_we;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (hazard && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
  assign stall_cnt = stall_cnt_q;

  logic unused_pending;
  assign unused_pending = ^pending;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - randomized and directed bench against a behavioural operand-fetch model
module tb_operand_fetch_stage;
  localparam int DATA_W    = 32;
  localparam int AW        = 5;
  localparam int CNT_W     = 8;
  localparam int STALL_MAX = 2 ** CNT_W - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_rd_we;
  logic [AW-1:0]     in_rs_a, in_rs_b, in_rd;
  logic [AW-1:0]     rf_address_a, rf_address_b, rf_address_w;
  logic              rf_enable_a, rf_enable_b, rf_enable_w;
  logic [DATA_W-1:0] rf_OutA, rf_OutB, rf_In;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid, out_ready, out_rd_we;
  logic [DATA_W-1:0] out_a, out_b;
  logic [AW-1:0]     out_rd;
  logic [CNT_W-1:0]  stall_cnt;

  operand_fetch_stage #(.DATA_W(DATA_W), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_address_a(rf_address_a), .rf_address_b(rf_address_b),
    .rf_enable_a(rf_enable_a), .rf_enable_b(rf_enable_b),
    .rf_OutA(rf_OutA), .rf_OutB(rf_OutB),
    .rf_address_w(rf_address_w), .rf_enable_w(rf_enable_w), .rf_In(rf_In),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the execute stage should see and which registers are in flight.
  bit [31:0]         m_pend;
  int                m_stall;
  bit                m_ov;
  logic [DATA_W-1:0] m_a, m_b;
  logic [AW-1:0]     m_rd;
  bit                m_we;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit m_busy(input logic [AW-1:0] r);
    return m_pend[r] && !(wb_valid && wb_rd == r);
  endfunction

  task automatic model_reset();
    m_pend = '0; m_stall = 0; m_ov = 0; m_a = '0; m_b = '0; m_rd = '0; m_we = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_ov);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_rd", {out_rd, out_rd_we}, {m_rd, m_we});
    chk("stall_cnt", stall_cnt, m_stall);
    chk("pending", dut.u_sb.pending, m_pend);
  endtask

  // Inputs are set at the falling edge; the model advances across one rising edge.
  task automatic step();
    bit hz, rdy;
    #1;
    hz  = in_valid && (m_busy(in_rs_a) || m_busy(in_rs_b) || (in_rd_we && m_busy(in_rd)));
    rdy = !hz && (!m_ov || out_ready);
    chk("in_ready", in_ready, rdy);
    chk("rf_read", {rf_address_a, rf_address_b, rf_enable_a, rf_enable_b},
        {in_rs_a, in_rs_b, in_valid, in_valid});
    chk("rf_write", {rf_address_w, rf_enable_w, rf_In}, {wb_rd, wb_valid, wb_data});
    if (hz && m_stall < STALL_MAX) m_stall++;
    if (wb_valid) m_pend[wb_rd] = 1'b0;
    if (in_valid && rdy) begin
      m_a  = (wb_valid && wb_rd == in_rs_a) ? wb_data : rf_OutA;
      m_b  = (wb_valid && wb_rd == in_rs_b) ? wb_data : rf_OutB;
      m_rd = in_rd;
      m_we = in_rd_we;
      m_ov = 1;
      if (in_rd_we) m_pend[in_rd] = 1'b1;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input int ra, input int rb, input int rd, input bit we);
    in_valid = v; in_rs_a = AW'(ra); in_rs_b = AW'(rb); in_rd = AW'(rd); in_rd_we = we;
  endtask

  task automatic set_wb(input bit v, input int rd, input logic [DATA_W-1:0] d);
    wb_valid = v; wb_rd = AW'(rd); wb_data = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    set_wb(0, 0, '0);
    rf_OutA = '0; rf_OutB = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Basic issue with register-file data.
    set_in(1, 3, 4, 5, 1); rf_OutA = 32'h11; rf_OutB = 32'h22;
    step();
    chk("t1_out_a", out_a, 32'h11);
    chk("t1_out_b", out_b, 32'h22);
    chk("t1_out_rd", {out_valid, out_rd}, {1'b1, 5'd5});
    chk("t1_pend5", dut.u_sb.pending[5], 1'b1);
    set_in(0, 0, 0, 0, 0);
    step();

    // RAW stall released by same-cycle writeback bypass.
    set_in(1, 0, 0, 7, 1); step();
    set_in(1, 7, 0, 0, 0); rf_OutA = 32'h1234;
    repeat (3) step();
    chk("t2_stall", stall_cnt, 3);
    set_wb(1, 7, 32'hDEAD);
    step();
    chk("t2_bypass", out_a, 32'hDEAD);
    chk("t2_pend7", dut.u_sb.pending[7], 1'b0);
    set_wb(0, 0, '0);

    // Re-issue of a register whose previous producer retires in the same cycle.
    set_in(1, 0, 0, 9, 1); step();
    set_in(1, 1, 1, 9, 1); set_wb(1, 9, 32'h99);
    step();
    chk("t3_pend9", dut.u_sb.pending[9], 1'b1);
    set_wb(0, 0, '0);

    // Backpressure holds the output register, then drain plus accept together.
    set_in(1, 1, 2, 0, 0); rf_OutA = 32'h55; rf_OutB = 32'h66; step();
    out_ready = 1'b0; set_in(1, 2, 3, 4, 0); rf_OutA = 32'hAA;
    repeat (3) step();
    chk("t4_hold", {out_valid, out_a}, {1'b1, 32'h55});
    out_ready = 1'b1;
    step();
    chk("t4_next", out_a, 32'hAA);

    // WAW stall.
    set_in(1, 0, 0, 2, 1); step();
    set_in(1, 0, 0, 2, 1);
    repeat (2) step();
    chk("t5_waw_ready", in_ready, 1'b0);
    set_wb(1, 2, 32'h22); step();
    set_wb(0, 0, '0); set_in(0, 0, 0, 0, 0); step();

    // Randomized traffic over a narrow register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 1) != 0);
      set_wb($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
      rf_OutA = $urandom; rf_OutB = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    set_wb(0, 0, '0); out_ready = 1'b1;

    // Asynchronous reset in the middle of a stall.
    set_in(1, 0, 0, 12, 1); step();
    set_in(1, 12, 0, 0, 0);
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_rf_en", {rf_enable_a, rf_enable_b, rf_enable_w}, {in_valid, in_valid, wb_valid});
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0); step();

    // Stall counter saturation.
    set_in(1, 0, 0, 1, 1); step();
    set_in(1, 1, 1, 0, 0);
    repeat (STALL_MAX + 5) step();
    chk("sat_cnt", stall_cnt, STALL_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
